apu_frame_sequencer: RTL and testbench
======================================

Name: apu_frame_sequencer

Overview:
Frame counter/scheduler for the APU channels. Divides the 1-clk CPU-cycle strobe into the APU-cycle strobe and generates the quarter-frame (envelope) and half-frame (length/sweep) strobes that drive the pulse channels. Implements the $4017 register (mode, IRQ inhibit) and the frame IRQ flag. Sits between the CPU bus decode and the pulse, triangle and noise channel instances.

Parameters:
STEP1, 7457, CPU-cycle count of the first quarter frame
STEP2, 14913, count of the second quarter/first half frame
STEP3, 22371, count of the third quarter frame
STEP4, 29829, count of the 4-step final quarter/half frame
STEP5, 37281, count of the 5-step final quarter/half frame
CNT_W, 16, width of the CPU-cycle counter

Ports:
clk_in  in  1  system clock
rst_n_in  in  1  reset, synchronous, active-low
cpu_cycle_pulse_in  in  1  1-clk strobe per CPU cycle
wr_in  in  1  write strobe for $4017
d_in  in  2  $4017 bits [7:6]: [1]=mode (1=5-step), [0]=IRQ inhibit
irq_clear_in  in  1  $4015 read strobe; clears frame IRQ
apu_clk_out  out  1  APU-cycle strobe (every 2nd CPU cycle)
eg_pulse_out  out  1  quarter-frame strobe
lc_pulse_out  out  1  half-frame strobe
frame_irq_out  out  1  frame IRQ flag (level)

Behaviour:
- One clock; reset is synchronous and active-low (rst_n_in sampled on clk_in rising edge).
- Reset: cyc=0, parity=0, mode=0, inhibit=0, pending=0, all outputs 0.
- All strobes are combinational-qualified with cpu_cycle_pulse_in: exactly 1 clk wide, coincident with that strobe, never asserted otherwise.
- parity toggles on every cpu_cycle_pulse_in; apu_clk_out = cpu_cycle_pulse_in & parity.
- cyc increments on each cpu_cycle_pulse_in; events decode on pre-increment cyc.
- 4-step (mode=0): quarter at STEP1, STEP2, STEP3, STEP4; half at STEP2, STEP4. IRQ set at STEP4-1, STEP4 and STEP4+1 if !inhibit. At STEP4+1, cyc wraps to 0 (next value 0).
- 5-step (mode=1): quarter at STEP1, STEP2, STEP3, STEP5; half at STEP2, STEP5. Nothing at STEP4. Never sets IRQ. At STEP5+1, cyc wraps to 0.
- Write to $4017 (wr_in=1):
  - inhibit <= d_in[0] immediately. If d_in[0]=1, frame_irq cleared the next clk.
  - Mode and reset are deferred. pending<=1, new_mode latched, delay<=3 if parity==1 at the write, else 4.
  - delay decrements per CPU cycle. On the CPU cycle where delay reaches 1:
    - mode<=new_mode and cyc<=0; this overrides the wrap and the increment.
    - If new_mode=1, eg_pulse_out and lc_pulse_out also fire on that CPU cycle.
    - Step events decoded from the old cyc still fire on that cycle.
  - A write while pending restarts the delay with the new value. Only the last write takes effect.
- IRQ flag: set by step logic; cleared by irq_clear_in or an inhibit write.
  - Set and clear in the same clk: set wins.
- Reset mid-operation: the pending write is discarded and all state returns to reset values.
- Counter arithmetic is unsigned CNT_W bits. cyc never exceeds STEP5+1.

Optional Feature:
APU_FRAME_IRQ_EN
- Defined: the IRQ flag, inhibit handling and irq_clear_in operate as above.
- Undefined: the IRQ flag logic is not built. frame_irq_out is tied 0, d_in[0] and irq_clear_in are ignored, and the step/strobe timing is unchanged.

Decomposition:
- Package apu_frame_pkg:
  - step count constants STEP1..STEP5
  - typedef enum frame_mode_t {MODE_4STEP, MODE_5STEP}
  - write-delay constants WR_DLY_ODD=3, WR_DLY_EVEN=4
- Sub-module apu_frame_wr_delay: holds the pending write, latches new_mode, runs the 3/4-cycle countdown and emits a 1-clk apply strobe with new_mode. Instantiated once.

Test Plan:
- Reset, then 30000 CPU cycles in mode 0 -> quarter strobes at cyc 7457, 14913, 22371, 29829; half strobes at 14913, 29829; frame_irq_out rises at cyc 29828; cyc wraps to 0 after 29830.
- Write d_in=2'b10 on an odd-parity cycle -> 3 CPU cycles later quarter and half strobes fire together and cyc=0. Next quarter at 7457, half at 14913, no strobe at 29829, quarter+half at 37281, and no IRQ ever.
- Mode 0 with IRQ set, then irq_clear_in -> frame_irq_out low next clk. irq_clear_in on cyc 29829 -> flag remains 1 (set wins).
- Write d_in=2'b01 while IRQ set -> flag clears next clk and stays 0 through the next 29829 boundary.
- Two writes 2 CPU cycles apart (mode 1, then mode 0) -> only mode 0 applied; no immediate strobes; apply occurs 3/4 cycles after the second write.
- rst_n_in low during a pending write -> all outputs 0 and no deferred apply after release. apu_clk_out asserts on every 2nd cpu_cycle_pulse_in, starting with the second.

Source files
------------

// File: rtl/apu_frame_pkg.sv
// Frame sequencer step counts, mode type, write-delay constants and step-decode helpers.
package apu_frame_pkg;

  localparam int CNT_W = 16;

  localparam logic [CNT_W-1:0] STEP1 = 16'd7457;
  localparam logic [CNT_W-1:0] STEP2 = 16'd14913;
  localparam logic [CNT_W-1:0] STEP3 = 16'd22371;
  localparam logic [CNT_W-1:0] STEP4 = 16'd29829;
  localparam logic [CNT_W-1:0] STEP5 = 16'd37281;

  localparam logic [2:0] WR_DLY_ODD  = 3'd3;
  localparam logic [2:0] WR_DLY_EVEN = 3'd4;

  typedef enum logic {
    MODE_4STEP = 1'b0,
    MODE_5STEP = 1'b1
  } frame_mode_t;

  function automatic logic [CNT_W-1:0] final_step(input frame_mode_t mode);
    if (mode == MODE_5STEP) begin
      final_step = STEP5;
    end else begin
      final_step = STEP4;
    end
  endfunction

  function automatic logic is_quarter(input logic [CNT_W-1:0] cyc, input frame_mode_t mode);
    is_quarter = (cyc == STEP1) || (cyc == STEP2) || (cyc == STEP3) || (cyc == final_step(mode));
  endfunction

  function automatic logic is_half(input logic [CNT_W-1:0] cyc, input frame_mode_t mode);
    is_half = (cyc == STEP2) || (cyc == final_step(mode));
  endfunction

  // The IRQ is raised on the three CPU cycles straddling the 4-step final step.
  function automatic logic in_irq_window(input logic [CNT_W-1:0] cyc, input frame_mode_t mode);
    in_irq_window = (mode == MODE_4STEP) && (cyc >= (STEP4 - 16'd1)) && (cyc <= (STEP4 + 16'd1));
  endfunction

endpackage

// File: rtl/apu_frame_wr_delay.sv
// Deferred $4017 mode/reset: holds the last write and emits a 1-clk apply strobe
// on the CPU cycle its 3/4-cycle countdown expires.
module apu_frame_wr_delay
  import apu_frame_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_cycle_pulse,
  input  logic        wr,
  input  logic        parity,
  input  frame_mode_t wr_mode,
  output logic        apply,
  output frame_mode_t new_mode
);

  logic        pending_r;
  logic [2:0]  delay_r;
  frame_mode_t new_mode_r;

  // A new write always restarts the countdown; otherwise count CPU cycles until apply.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_r  <= 1'b0;
      delay_r    <= 3'd0;
      new_mode_r <= MODE_4STEP;
    end else if (wr) begin
      pending_r  <= 1'b1;
      new_mode_r <= wr_mode;
      delay_r    <= parity ? WR_DLY_ODD : WR_DLY_EVEN;
    end else if (pending_r && cpu_cycle_pulse) begin
      delay_r   <= delay_r - 3'd1;
      pending_r <= (delay_r != 3'd1);
    end
  end

  assign apply    = pending_r && cpu_cycle_pulse && !wr && (delay_r == 3'd1);
  assign new_mode = new_mode_r;

endmodule

// File: rtl/apu_frame_sequencer.sv
// APU frame counter: APU-cycle, quarter-frame and half-frame strobes plus $4017 handling.
// The frame IRQ flag and inhibit logic are built only when APU_FRAME_IRQ_EN is defined.
module apu_frame_sequencer
  import apu_frame_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       cpu_cycle_pulse_in,
  input  logic       wr_in,
  input  logic [1:0] d_in,
  input  logic       irq_clear_in,
  output logic       apu_clk_out,
  output logic       eg_pulse_out,
  output logic       lc_pulse_out,
  output logic       frame_irq_out
);

  logic [CNT_W-1:0] cyc_r;
  logic [CNT_W-1:0] cyc_next_s;
  logic             parity_r;
  frame_mode_t      mode_r;
  frame_mode_t      wr_mode_s;
  frame_mode_t      new_mode_s;
  logic             apply_s;
  logic             quarter_s;
  logic             half_s;

  assign wr_mode_s = frame_mode_t'(d_in[1]);

  apu_frame_wr_delay u_wr_delay (
    .clk             (clk_in),
    .rst_n           (rst_n_in),
    .cpu_cycle_pulse (cpu_cycle_pulse_in),
    .wr              (wr_in),
    .parity          (parity_r),
    .wr_mode         (wr_mode_s),
    .apply           (apply_s),
    .new_mode        (new_mode_s)
  );

  // Step decode on the pre-increment count; an applied write overrides wrap and increment.
  always_comb begin
    quarter_s  = 1'b0;
    half_s     = 1'b0;
    cyc_next_s = cyc_r;
    if (cpu_cycle_pulse_in) begin
      quarter_s = is_quarter(cyc_r, mode_r) || (apply_s && (new_mode_s == MODE_5STEP));
      half_s    = is_half(cyc_r, mode_r) || (apply_s && (new_mode_s == MODE_5STEP));
      if (apply_s) begin
        cyc_next_s = {CNT_W{1'b0}};
      end else if (cyc_r >= (final_step(mode_r) + 16'd1)) begin
        cyc_next_s = {CNT_W{1'b0}};
      end else begin
        cyc_next_s = cyc_r + 16'd1;
      end
    end else begin
      quarter_s  = 1'b0;
      half_s     = 1'b0;
      cyc_next_s = cyc_r;
    end
  end

  // Cycle counter, CPU-cycle parity and active mode.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      cyc_r    <= {CNT_W{1'b0}};
      parity_r <= 1'b0;
      mode_r   <= MODE_4STEP;
    end else begin
      cyc_r <= cyc_next_s;
      if (cpu_cycle_pulse_in) begin
        parity_r <= ~parity_r;
      end
      if (apply_s) begin
        mode_r <= new_mode_s;
      end
    end
  end

  assign apu_clk_out  = cpu_cycle_pulse_in & parity_r;
  assign eg_pulse_out = quarter_s;
  assign lc_pulse_out = half_s;

`ifdef APU_FRAME_IRQ_EN
  logic inhibit_r;
  logic irq_r;
  logic irq_set_s;

  assign irq_set_s = cpu_cycle_pulse_in && !inhibit_r && in_irq_window(cyc_r, mode_r);

  // Inhibit tracks every $4017 write; a same-clk set beats any clear.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      inhibit_r <= 1'b0;
      irq_r     <= 1'b0;
    end else begin
      if (wr_in) begin
        inhibit_r <= d_in[0];
      end
      if (irq_set_s) begin
        irq_r <= 1'b1;
      end else if (irq_clear_in || (wr_in && d_in[0])) begin
        irq_r <= 1'b0;
      end
    end
  end

  assign frame_irq_out = irq_r;
`else
  logic unused_irq_s;
  assign unused_irq_s  = ^{d_in[0], irq_clear_in};
  assign frame_irq_out = 1'b0;
`endif

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Randomized-gap bench for apu_frame_sequencer against a step-table reference model.
module tb_apu_frame_sequencer;

  localparam int S1 = 7457;
  localparam int S2 = 14913;
  localparam int S3 = 22371;
  localparam int S4 = 29829;
  localparam int S5 = 37281;
  localparam int RUN_LIMIT = 45000;
`ifdef APU_FRAME_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic       clk_in = 1'b0;
  logic       rst_n_in;
  logic       cpu_cycle_pulse_in;
  logic       wr_in;
  logic [1:0] d_in;
  logic       irq_clear_in;
  logic       apu_clk_out;
  logic       eg_pulse_out;
  logic       lc_pulse_out;
  logic       frame_irq_out;

  int errors = 0;
  int checks = 0;
  int cnt_eg, cnt_lc, cnt_apu;

  // Reference model: frame position, parity, mode and pending write.
  int m_cyc, m_left;
  bit m_par, m_mode5, m_inh, m_irq, m_pend, m_newmode;

  always #5 clk_in = ~clk_in;

  apu_frame_sequencer dut (
    .clk_in             (clk_in),
    .rst_n_in           (rst_n_in),
    .cpu_cycle_pulse_in (cpu_cycle_pulse_in),
    .wr_in              (wr_in),
    .d_in               (d_in),
    .irq_clear_in       (irq_clear_in),
    .apu_clk_out        (apu_clk_out),
    .eg_pulse_out       (eg_pulse_out),
    .lc_pulse_out       (lc_pulse_out),
    .frame_irq_out      (frame_irq_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0; m_left = 0; m_par = 0; m_mode5 = 0;
    m_inh = 0; m_irq = 0; m_pend = 0; m_newmode = 0;
  endtask

  function automatic bit rp();
    return $urandom_range(0, 31) != 0;
  endfunction

  // One clock: drive at negedge, compare just after, advance the model at posedge.
  task automatic tick(input bit rst, input bit p, input bit w, input bit [1:0] d, input bit c);
    bit eq, eh, ea, apply, set;
    int last;
    @(negedge clk_in);
    rst_n_in = rst; cpu_cycle_pulse_in = p; wr_in = w; d_in = d; irq_clear_in = c;
    last  = m_mode5 ? S5 : S4;
    apply = p && m_pend && !w && (m_left == 1);
    eq    = p && (m_cyc == S1 || m_cyc == S2 || m_cyc == S3 || m_cyc == last || (apply && m_newmode));
    eh    = p && (m_cyc == S2 || m_cyc == last || (apply && m_newmode));
    ea    = p && m_par;
    set   = IRQ_ON && p && !m_mode5 && !m_inh && (m_cyc >= S4 - 1) && (m_cyc <= S4 + 1);
    #1;
    check_eq("apu_clk", apu_clk_out, ea);
    check_eq("eg_pulse", eg_pulse_out, eq);
    check_eq("lc_pulse", lc_pulse_out, eh);
    check_eq("frame_irq", frame_irq_out, m_irq);
    cnt_eg  += int'(eg_pulse_out);
    cnt_lc  += int'(lc_pulse_out);
    cnt_apu += int'(apu_clk_out);
    @(posedge clk_in);
    if (!rst) begin
      model_reset();
    end else begin
      if (set) m_irq = 1;
      else if (c || (w && d[0])) m_irq = 0;
      if (w) begin
        m_inh = d[0]; m_pend = 1; m_newmode = d[1]; m_left = m_par ? 3 : 4;
      end else if (p && m_pend) begin
        m_left--;
      end
      if (p) begin
        m_cyc = apply ? 0 : (m_cyc + 1) % (last + 2);
        m_par = !m_par;
      end
      if (apply) begin
        m_mode5 = m_newmode; m_pend = 0;
      end
    end
  endtask

  task automatic run_to(input int target, input bit rclr);
    int n;
    n = 0;
    while (m_cyc != target && n < RUN_LIMIT) begin
      tick(1'b1, rp(), 1'b0, 2'b00, rclr && ($urandom_range(0, 63) == 0));
      n++;
    end
    check_eq("run_to_bound", (n < RUN_LIMIT), 1'b1);
  endtask

  task automatic pulses(input int n);
    int k;
    bit p;
    k = 0;
    while (k < n) begin
      p = rp();
      tick(1'b1, p, 1'b0, 2'b00, 1'b0);
      if (p) k++;
    end
  endtask

  task automatic clr_counts();
    cnt_eg = 0; cnt_lc = 0; cnt_apu = 0;
  endtask

  initial begin
    rst_n_in = 1'b0; cpu_cycle_pulse_in = 1'b0; wr_in = 1'b0; d_in = 2'b00; irq_clear_in = 1'b0;
    clr_counts();
    repeat (3) @(posedge clk_in);
    model_reset();
    tick(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    clr_counts();

    // 4-step frame, IRQ window, set-wins and wrap
    run_to(S4 - 1, 1'b1);
    check_eq("q_before_s4", cnt_eg, 3);
    check_eq("h_before_s4", cnt_lc, 1);
    tick(1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
    #1 check_eq("irq_rise_29828", frame_irq_out, IRQ_ON);
    tick(1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
    #1 check_eq("irq_clear_next_clk", frame_irq_out, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 2'b00, 1'b1);
    #1 check_eq("irq_set_wins_29829", frame_irq_out, IRQ_ON);
    check_eq("q_at_s4", cnt_eg, 4);
    check_eq("h_at_s4", cnt_lc, 2);
    tick(1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
    clr_counts();
    run_to(S1 + 1, 1'b0);
    check_eq("q_after_wrap", cnt_eg, 1);
    check_eq("h_after_wrap", cnt_lc, 0);
    #1 check_eq("irq_held", frame_irq_out, IRQ_ON);
    tick(1'b1, 1'b0, 1'b1, 2'b01, 1'b0);
    #1 check_eq("irq_inhibit_clear", frame_irq_out, 1'b0);
    pulses(6);

    // Switch to 5-step on an odd-parity cycle
    while (!m_par) tick(1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
    clr_counts();
    tick(1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
    pulses(2);
    check_eq("odd_dly_early", cnt_eg, 0);
    pulses(1);
    check_eq("apply5_q", cnt_eg, 1);
    check_eq("apply5_h", cnt_lc, 1);
    run_to(S4 + 1, 1'b1);
    check_eq("q_no_s4_5step", cnt_eg, 4);
    check_eq("h_no_s4_5step", cnt_lc, 2);
    run_to(S5 + 1, 1'b1);
    check_eq("q_at_s5", cnt_eg, 5);
    check_eq("h_at_s5", cnt_lc, 3);
    pulses(3);
    #1 check_eq("no_irq_5step", frame_irq_out, 1'b0);

    // Two writes two CPU cycles apart: only the later 4-step write applies
    clr_counts();
    tick(1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
    pulses(2);
    tick(1'b1, 1'b0, 1'b1, 2'b00, 1'b0);
    pulses(8);
    check_eq("dbl_no_q", cnt_eg, 0);
    check_eq("dbl_no_h", cnt_lc, 0);

    // Even-parity write waits four CPU cycles
    while (m_par) tick(1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
    clr_counts();
    tick(1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
    pulses(3);
    check_eq("even_dly_early", cnt_eg, 0);
    pulses(1);
    check_eq("even_dly_q", cnt_eg, 1);
    check_eq("even_dly_h", cnt_lc, 1);

    // Reset while a write is pending
    tick(1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
    pulses(1);
    repeat (3) tick(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    #1;
    check_eq("rst_apu", apu_clk_out, 1'b0);
    check_eq("rst_eg", eg_pulse_out, 1'b0);
    check_eq("rst_lc", lc_pulse_out, 1'b0);
    check_eq("rst_irq", frame_irq_out, 1'b0);
    clr_counts();
    pulses(10);
    check_eq("apu_half_rate", cnt_apu, 5);
    check_eq("no_apply_after_rst_q", cnt_eg, 0);
    check_eq("no_apply_after_rst_h", cnt_lc, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
